ps2_kbd_rx_fifo: RTL and testbench
==================================

Name: ps2_kbd_rx_fifo

Overview:
PS/2 keyboard receiver. Generalises the single-byte receiver with:
- parametrised event FIFO
- E0 (extended) and F0 (break) prefix decoding into one event word
- asynchronous active-low reset
- frame timeout recovery, error reporting and overflow flagging

Sits between the PS/2 pins and the keyboard consumer (scan-code display / ASCII logic), which pops events at its own pace.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2
CNT_WIDTH, 8, width of key_count release counter
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
ps2_clk  in  1  PS/2 clock pin, asynchronous
ps2_data  in  1  PS/2 data pin, asynchronous
rd_en  in  1  pop request; honoured only when rd_valid=1
clr_ovf  in  1  clears sticky overflow
rd_valid  out  1  FIFO non-empty
rd_data  out  10  head event: [9]=break, [8]=extended, [7:0]=scan code
level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
key_count  out  CNT_WIDTH  number of break events accepted into the FIFO, wraps modulo 2^CNT_WIDTH
key_down  out  1  1 after a make event, 0 after a break event
frame_err  out  1  one-cycle pulse on bad start, stop or parity, or on timeout abort
overflow  out  1  sticky; set when an event is dropped because the FIFO is full

Behaviour:
- Reset (clrn=0, async): all state cleared:
  - bit counter 0, decoder in IDLE, FIFO empty, level=0, rd_valid=0, rd_data=0
  - key_count=0, key_down=0, frame_err=0, overflow=0, timeout counter 0
  - Synchroniser flops reset to 1 (bus idle).
  - Reset mid-frame discards the partial frame.
- Synchronisation and sampling:
  - ps2_clk passes through a 3-flop synchroniser. ps2_data passes through 2 flops, aligned so it is sampled with the clock edge.
  - Sample strobe = synchronised falling edge of ps2_clk: one clk-cycle pulse.
- Frame assembly:
  - Bit counter 0..10. Strobes 0..9 shift bits into a 10-bit buffer (start, 8 data LSB-first, parity).
  - Strobe 10 checks: start==0, stop==1, XOR of data+parity==1 (odd parity).
  - Pass: byte handed to the decoder in the same cycle. Fail: frame_err pulses for 1 cycle and the byte is discarded.
  - Counter returns to 0 on either outcome.
- Timeout:
  - While the bit counter is nonzero, a cycle counter runs; it is cleared on every strobe.
  - Reaching TIMEOUT_CYCLES resets the bit counter to 0 and pulses frame_err.
  - The decoder state is kept.
- Decoder FSM, states IDLE, EXT, BRK, EXT_BRK:
  - IDLE: E0 -> EXT; F0 -> BRK; other byte -> emit {0,0,byte}
  - EXT: F0 -> EXT_BRK; E0 -> EXT; other -> emit {0,1,byte}, go IDLE
  - BRK: E0 -> EXT_BRK; F0 -> BRK; other -> emit {1,0,byte}, go IDLE
  - EXT_BRK: E0/F0 -> stay; other -> emit {1,1,byte}, go IDLE
- Emit is a 1-cycle push.
  - On an accepted break push: key_count+1 and key_down<=0.
  - On an accepted make push: key_down<=1.
  - A dropped push changes neither.
- FIFO:
  - Show-ahead: rd_data = head entry whenever rd_valid=1; rd_data holds 0 when empty.
  - Pop on rd_en & rd_valid, with 1-cycle latency to the next head.
  - level updates the cycle after a push or pop. Simultaneous push and pop leaves level unchanged.
- Full-FIFO rules:
  - Push with no pop: event dropped, overflow<=1.
  - Push with simultaneous pop: push accepted.
  - Empty FIFO with push and rd_en: pop ignored, push accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow is cleared by clr_ovf. If clr_ovf and a drop occur in the same cycle, the set wins.

Optional Feature:
PS2_KBD_TYPEMATIC_FILTER_EN
- Defined: the block holds the last accepted make event {ext,code}. A make event equal to it (keyboard auto-repeat) is not pushed and does not touch key_down. A break event, or a different make, updates or clears the held value. Reset clears it.
- Undefined: every make event is pushed, including repeats.

Test Plan:
- Frame 0x1C (parity 0, stop 1), rd_en=0 -> rd_valid=1, rd_data=10'h01C, level=1, key_down=1, key_count=0.
- Frames E0,F0,75 -> single event rd_data=10'h375, key_count=1, key_down=0, level=1.
- Frame 0x1C with parity bit=1 -> frame_err pulses exactly 1 cycle, level unchanged.
- 4 data bits then ps2_clk idle for TIMEOUT_CYCLES -> frame_err pulse, next full 0x32 frame yields rd_data=10'h032.
- FIFO_DEPTH=4: 5 make frames, no pops -> level=4, overflow=1, head is first code. clr_ovf -> overflow=0. Push coincident with pop at full -> level stays 4.
- clrn low mid-frame (bit 6) -> all outputs 0 immediately. With PS2_KBD_TYPEMATIC_FILTER_EN: 1C,1C,1C,F0,1C -> exactly 2 events (10'h01C, 10'h21C).

Source files
------------

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: frame assembly, E0/F0 prefix decoding and show-ahead event FIFO.
// Optional auto-repeat suppression is enabled by defining PS2_KBD_TYPEMATIC_FILTER_EN.
module ps2_kbd_rx_fifo #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                             clk,
  input  logic                             clrn,
  input  logic                             ps2_clk,
  input  logic                             ps2_data,
  input  logic                             rd_en,
  input  logic                             clr_ovf,
  output logic                             rd_valid,
  output logic [9:0]                       rd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
  output logic [CNT_WIDTH-1:0]             key_count,
  output logic                             key_down,
  output logic                             frame_err,
  output logic                             overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LW-1:0] DepthL = LW'(FIFO_DEPTH);
  localparam logic [TW-1:0] ToLast = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} dec_state_e;

  // Synchronisers: data is one flop shorter so it lines up with the clock edge detect.
  logic [2:0]     clk_sync_q;
  logic [1:0]     dat_sync_q;
  logic           strobe;
  logic           bit_in;

  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [9:0]     shreg_q, shreg_d;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic           byte_valid;
  logic           bad_frame;
  logic           timeout;
  logic [7:0]     rx_byte;

  dec_state_e     state_q, state_d;
  logic           push;
  logic           ev_brk;
  logic           ev_ext;
  logic [9:0]     ev_word;
  logic           push_req;

  logic [9:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           do_pop;
  logic           full;
  logic           push_ok;
  logic           drop;

  logic [CNT_WIDTH-1:0] key_count_q, key_count_d;
  logic           key_down_q, key_down_d;
  logic           frame_err_q;
  logic           overflow_q, overflow_d;

  assign strobe  = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_in  = dat_sync_q[1];
  assign rx_byte = shreg_q[8:1];

  // Frame assembly and inter-bit timeout
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    to_cnt_d   = to_cnt_q;
    byte_valid = 1'b0;
    bad_frame  = 1'b0;
    timeout    = 1'b0;
    if (strobe) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (!shreg_q[0] && bit_in && (^shreg_q[9:1])) begin
          byte_valid = 1'b1;
        end else begin
          bad_frame = 1'b1;
        end
      end else begin
        shreg_d   = {bit_in, shreg_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == ToLast) begin
        timeout   = 1'b1;
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Prefix decoder
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    if (byte_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_byte == 8'hE0)      state_d = StExt;
          else if (rx_byte == 8'hF0) state_d = StBrk;
          else                       push = 1'b1;
        end
        StExt: begin
          if (rx_byte == 8'hF0)      state_d = StExtBrk;
          else if (rx_byte != 8'hE0) begin
            push    = 1'b1;
            ev_ext  = 1'b1;
            state_d = StIdle;
          end
        end
        StBrk: begin
          if (rx_byte == 8'hE0)      state_d = StExtBrk;
          else if (rx_byte != 8'hF0) begin
            push    = 1'b1;
            ev_brk  = 1'b1;
            state_d = StIdle;
          end
        end
        StExtBrk: begin
          if (rx_byte != 8'hE0 && rx_byte != 8'hF0) begin
            push    = 1'b1;
            ev_brk  = 1'b1;
            ev_ext  = 1'b1;
            state_d = StIdle;
          end
        end
      endcase
    end
  end

  assign ev_word = {ev_brk, ev_ext, rx_byte};

`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
  logic       held_vld_q;
  logic [8:0] held_q;
  logic       repeat_make;

  assign repeat_make = push & ~ev_brk & held_vld_q & (held_q == {ev_ext, rx_byte});
  assign push_req    = push & ~repeat_make;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      held_vld_q <= 1'b0;
      held_q     <= '0;
    end else if (push_req && ev_brk) begin
      held_vld_q <= 1'b0;
    end else if (push_ok && !ev_brk) begin
      held_vld_q <= 1'b1;
      held_q     <= {ev_ext, rx_byte};
    end
  end
`else
  assign push_req = push;
`endif

  // FIFO control; a pop at full makes room for a coincident push
  assign do_pop  = rd_en & rd_valid;
  assign full    = (level_q == DepthL);
  assign push_ok = push_req & (~full | do_pop);
  assign drop    = push_req & full & ~do_pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    key_count_d = key_count_q;
    key_down_d  = key_down_q;
    overflow_d  = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (ev_brk) begin
        key_count_d = key_count_q + CNT_WIDTH'(1);
        key_down_d  = 1'b0;
      end else begin
        key_down_d = 1'b1;
      end
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !do_pop)      level_d = level_q + LW'(1);
    else if (!push_ok && do_pop) level_d = level_q - LW'(1);
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= ev_word;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= 3'b111;
      dat_sync_q  <= 2'b11;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= '0;
      to_cnt_q    <= '0;
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      key_count_q <= '0;
      key_down_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q  <= {dat_sync_q[0], ps2_data};
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      to_cnt_q    <= to_cnt_d;
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      key_count_q <= key_count_d;
      key_down_q  <= key_down_d;
      frame_err_q <= bad_frame | timeout;
      overflow_q  <= overflow_d;
    end
  end

  assign rd_valid  = (level_q != '0);
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : 10'd0;
  assign level     = level_q;
  assign key_count = key_count_q;
  assign key_down  = key_down_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Directed self-checking bench for ps2_kbd_rx_fifo (small FIFO and short timeout).
module tb_ps2_kbd_rx_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 300;
  localparam int unsigned HALF  = 20;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       rd_valid;
  logic [9:0] rd_data;
  logic [2:0] level;
  logic [7:0] key_count;
  logic       key_down;
  logic       frame_err;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;

  ps2_kbd_rx_fifo #(
    .FIFO_DEPTH(DEPTH),
    .CNT_WIDTH(8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .rd_en(rd_en),
    .clr_ovf(clr_ovf),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .level(level),
    .key_count(key_count),
    .key_down(key_down),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Counts clock cycles during which frame_err is high
  always @(negedge clk) if (frame_err) err_seen <= err_seen + 1;

  task automatic ps2_bit(input logic b);
    @(negedge clk); ps2_data = b;
    repeat (HALF) @(negedge clk); ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk); ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par);
    logic [10:0] fr;
    fr = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(fr[i]);
    repeat (6) @(negedge clk);
  endtask

  // Sends a good frame and asserts rd_en exactly in the cycle the event is pushed
  task automatic send_frame_pop(input logic [7:0] code);
    logic [10:0] fr;
    fr = {1'b1, ~^code, code, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(fr[i]);
    @(negedge clk); ps2_data = 1'b1;
    repeat (HALF) @(negedge clk); ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    repeat (HALF) @(negedge clk); ps2_clk = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 10'h000) begin bad++; $display("FAIL rst_data got=%h exp=000", rd_data); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
    total++; if (key_count !== 8'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", key_count); end
    total++; if ({key_down, frame_err, overflow} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got=%b exp=000", {key_down, frame_err, overflow});
    end
    clrn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_make();
    send_frame(8'h1C, 1'b0);
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL make_valid got=%b exp=1", rd_valid); end
    total++; if (rd_data !== 10'h01C) begin bad++; $display("FAIL make_data got=%h exp=01c", rd_data); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL make_level got=%0d exp=1", level); end
    total++; if (key_down !== 1'b1) begin bad++; $display("FAIL make_down got=%b exp=1", key_down); end
    total++; if (key_count !== 8'd0) begin bad++; $display("FAIL make_count got=%0d exp=0", key_count); end
    pop();
    @(negedge clk);
    total++; if ({rd_valid, level} !== 4'b0000) begin
      bad++; $display("FAIL make_pop got=%b/%0d exp=0/0", rd_valid, level);
    end
    total++; if (rd_data !== 10'h000) begin bad++; $display("FAIL empty_data got=%h exp=000", rd_data); end
  endtask

  task automatic test_ext_break();
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    total++; if (rd_data !== 10'h375) begin bad++; $display("FAIL extbrk_data got=%h exp=375", rd_data); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL extbrk_level got=%0d exp=1", level); end
    total++; if (key_count !== 8'd1) begin bad++; $display("FAIL extbrk_count got=%0d exp=1", key_count); end
    total++; if (key_down !== 1'b0) begin bad++; $display("FAIL extbrk_down got=%b exp=0", key_down); end
    pop();
    @(negedge clk);
  endtask

  task automatic test_parity_err();
    int base;
    base = err_seen;
    send_frame(8'h1C, 1'b1);
    total++; if (err_seen - base !== 1) begin
      bad++; $display("FAIL parity_err_cycles got=%0d exp=1", err_seen - base);
    end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL parity_level got=%0d exp=0", level); end
  endtask

  task automatic test_timeout();
    int base;
    base = err_seen;
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    repeat (TO + 50) @(negedge clk);
    total++; if (err_seen - base !== 1) begin
      bad++; $display("FAIL timeout_err got=%0d exp=1", err_seen - base);
    end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL timeout_level got=%0d exp=0", level); end
    send_frame(8'h32, 1'b0);
    total++; if (rd_data !== 10'h032) begin bad++; $display("FAIL timeout_next got=%h exp=032", rd_data); end
    total++; if (err_seen - base !== 1) begin
      bad++; $display("FAIL timeout_recover_err got=%0d exp=1", err_seen - base);
    end
    pop();
    @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [9:0] exp_q [4];
    exp_q = '{10'h016, 10'h01A, 10'h01E, 10'h029};
    send_frame(8'h15, 1'b0);
    send_frame(8'h16, 1'b0);
    send_frame(8'h1A, 1'b0);
    send_frame(8'h1E, 1'b0);
    send_frame(8'h21, 1'b0);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    total++; if (rd_data !== 10'h015) begin bad++; $display("FAIL ovf_head got=%h exp=015", rd_data); end
    total++; if (key_count !== 8'd1) begin bad++; $display("FAIL ovf_count got=%0d exp=1", key_count); end
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    send_frame_pop(8'h29);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL full_pushpop_level got=%0d exp=4", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_pushpop_ovf got=%b exp=0", overflow); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_data !== exp_q[i]) begin
        bad++; $display("FAIL ovf_order%0d got=%h exp=%h", i, rd_data, exp_q[i]);
      end
      pop();
      @(negedge clk);
    end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL ovf_drain got=%0d exp=0", level); end
  endtask

  task automatic test_reset_midframe();
    int base;
    send_frame(8'h1C, 1'b0);
    for (int i = 0; i < 6; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    @(negedge clk); clrn = 1'b0;
    #1;
    total++; if ({rd_valid, level} !== 4'b0000) begin
      bad++; $display("FAIL midrst_fifo got=%b/%0d exp=0/0", rd_valid, level);
    end
    total++; if (rd_data !== 10'h000) begin bad++; $display("FAIL midrst_data got=%h exp=000", rd_data); end
    total++; if ({key_count, key_down} !== 9'd0) begin
      bad++; $display("FAIL midrst_keys got=%0d/%b exp=0/0", key_count, key_down);
    end
    repeat (2) @(negedge clk); clrn = 1'b1;
    repeat (2) @(negedge clk);
    base = err_seen;
    send_frame(8'h32, 1'b0);
    total++; if (rd_data !== 10'h032 || level !== 3'd1) begin
      bad++; $display("FAIL midrst_next got=%h/%0d exp=032/1", rd_data, level);
    end
    total++; if (err_seen - base !== 0) begin
      bad++; $display("FAIL midrst_err got=%0d exp=0", err_seen - base);
    end
    pop();
    @(negedge clk);
  endtask

  task automatic test_typematic();
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
    logic [9:0] exp_q [4];
    int n;
    exp_q = '{10'h01C, 10'h21C, 10'h000, 10'h000};
    n = 2;
`else
    logic [9:0] exp_q [4];
    int n;
    exp_q = '{10'h01C, 10'h01C, 10'h01C, 10'h21C};
    n = 4;
`endif
    send_frame(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    total++; if (level !== 3'(n)) begin bad++; $display("FAIL tm_level got=%0d exp=%0d", level, n); end
    total++; if (key_count !== 8'd1) begin bad++; $display("FAIL tm_count got=%0d exp=1", key_count); end
    for (int i = 0; i < n; i++) begin
      total++; if (rd_data !== exp_q[i]) begin
        bad++; $display("FAIL tm_event%0d got=%h exp=%h", i, rd_data, exp_q[i]);
      end
      pop();
      @(negedge clk);
    end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL tm_empty got=%b exp=0", rd_valid); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_ext_break();
    test_parity_err();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    test_typematic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
